vlsu_cam_alloc: RTL and testbench
=================================

Name: vlsu_cam_alloc

Overview:
- Circular-queue allocator directly upstream of vlsu_cam_top.
- Accepts new entries from the VLSU issue stage and assigns each a CAM slot at the tail.
- Drives the CAM write port and head pointer, and retires entries at the head in order.
- Builds the per-read-port age-ordered enable masks that restrict CAM comparisons to valid, older entries.

Parameters:
- WIDTH, 50, CAM data width in bits.
- DEPTH, 32, number of CAM entries; must be a power of two.
- READ, 3, number of CAM read/compare ports.
- ADDRESS, $clog2(DEPTH), entry index width.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all entries.
- alloc_valid_i  in  1  allocation request.
- alloc_data_i  in  WIDTH  data to store at the tail.
- alloc_ready_o  out  1  allocation accepted when high together with alloc_valid_i.
- alloc_idx_o  out  ADDRESS  slot index assigned to the current request (the tail).
- retire_i  in  1  pop the head entry.
- query_valid_i  in  READ  per-port age-restriction enable.
- query_idx_i  in  READ x ADDRESS  per-port index of the requesting entry.
- cam_write_o  out  1  CAM write strobe.
- cam_write_addr_o  out  ADDRESS  CAM write address.
- cam_write_data_o  out  WIDTH  CAM write data.
- cam_head_o  out  ADDRESS  head pointer to the CAM.
- cam_enable_o  out  READ x DEPTH  per-port compare enable mask.
- count_o  out  ADDRESS+1  number of valid entries.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.

Behaviour:
- Reset is asynchronous on arst_n low. The following are all set to zero:
  - head, tail, count, valid[DEPTH].
  - cam_write_o, cam_write_addr_o, cam_write_data_o.
- Consequent values during and after reset: empty_o = 1, full_o = 0, alloc_ready_o = 1, cam_enable_o = 0.
- alloc_ready_o = !full_o. It does not account for a retire in the same cycle, so there is no combinational path from retire_i.
- Alloc handshake occurs on alloc_valid_i && alloc_ready_o at a clk rising edge:
  - valid[tail] is set.
  - tail increments modulo DEPTH.
  - cam_write_o / addr / data are registered: they equal 1 / old tail / alloc_data_i on the following cycle, then return to cam_write_o = 0 unless another handshake occurred.
  - Latency from handshake to CAM write strobe is 1 cycle.
- alloc_idx_o = tail, combinational from the register.
- Retire on retire_i && !empty_o:
  - valid[head] is cleared.
  - head increments modulo DEPTH.
  - retire_i while empty is ignored: no state change.
- Simultaneous alloc and retire: both take effect and count is unchanged. When full, the alloc is refused and only the retire happens.
- count_o rules: +1 on alloc only, −1 on retire only, unchanged when both or neither occur.
- Wrap-around: pointers wrap DEPTH−1 → 0. Full is distinguished from empty by count, not by pointer equality.
- cam_head_o = head register.
- Enable mask, combinational from registered state and query inputs:
  - age(x) = (x − head) mod DEPTH.
  - cam_enable_o[r][j] = valid[j] && (!query_valid_i[r] || age(j) < age(query_idx_i[r])).
  - A query at the head therefore gives an all-zero mask for that port.
- Flush (flush_i high at a clk edge):
  - Clears valid, head, tail and count to 0.
  - Overrides any alloc or retire in the same cycle: the request is neither accepted nor written, and cam_write_o is 0 on the next cycle.
  - alloc_ready_o is not gated by flush_i.
- Reset mid-operation: all state clears immediately and asynchronously. A pending registered CAM write is dropped (cam_write_o falls with arst_n).

Test Plan:
1. Fill: after reset, present 32 back-to-back allocs with data 1..32:
   - cam_write_o is high for 32 cycles starting 1 cycle after the first handshake, with addr 0..31 and data 1..32.
   - After the 32nd alloc: full_o = 1, alloc_ready_o = 0, count_o = 32.
   - A 33rd alloc is held with no write.
2. Wrap: from full, retire 4 times, then alloc 4 with data 100..103:
   - Writes go to addr 0..3, head = 4, tail = 4, count_o = 32.
3. Age mask: head = 4, entries 4..31 and 0..3 valid; port 1 query_valid = 1, query_idx = 2:
   - cam_enable_o[1] has bits 4..31 and 0..1 set, bits 2..3 clear.
   - With query_idx = 4: mask = 0.
   - With query_valid = 0: mask = all ones.
4. Simultaneous events, with count = 10:
   - alloc + retire in the same cycle → count_o stays 10, head and tail both advance by 1.
   - When full: alloc + retire → only the retire happens, count_o = 31.
5. Flush: with 10 valid entries, assert flush_i together with an alloc:
   - Next cycle count_o = 0, empty_o = 1, cam_write_o = 0, head = tail = 0, cam_enable_o = 0.
6. Reset mid-write: drop arst_n in the cycle after a handshake:
   - cam_write_o falls immediately and all outputs reach their reset values.
   - Allocation resumes at index 0 after arst_n is released.

Source files
------------

// File: rtl/vlsu_cam_alloc.sv
// Circular-queue slot allocator feeding vlsu_cam_top: assigns tail slots, retires from head,
// and builds per-read-port age-ordered compare enable masks.
module vlsu_cam_alloc #(
    parameter int unsigned WIDTH   = 50,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned READ    = 3,
    parameter int unsigned ADDRESS = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic                              flush_i,
    input  logic                              alloc_valid_i,
    input  logic [WIDTH-1:0]                  alloc_data_i,
    output logic                              alloc_ready_o,
    output logic [ADDRESS-1:0]                alloc_idx_o,
    input  logic                              retire_i,
    input  logic [READ-1:0]                   query_valid_i,
    input  logic [READ-1:0][ADDRESS-1:0]      query_idx_i,
    output logic                              cam_write_o,
    output logic [ADDRESS-1:0]                cam_write_addr_o,
    output logic [WIDTH-1:0]                  cam_write_data_o,
    output logic [ADDRESS-1:0]                cam_head_o,
    output logic [READ-1:0][DEPTH-1:0]        cam_enable_o,
    output logic [ADDRESS:0]                  count_o,
    output logic                              full_o,
    output logic                              empty_o
);

    localparam logic [ADDRESS:0] FullCount = (ADDRESS + 1)'(DEPTH);
    localparam logic [ADDRESS:0] OneCount  = (ADDRESS + 1)'(1);

    logic [ADDRESS-1:0] head_q, head_d;
    logic [ADDRESS-1:0] tail_q, tail_d;
    logic [ADDRESS:0]   count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               wr_q, wr_d;
    logic [ADDRESS-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]   wr_data_q, wr_data_d;
    logic               do_alloc, do_retire;

    assign full_o        = (count_q == FullCount);
    assign empty_o       = (count_q == '0);
    // Deliberately ignores retire_i so there is no combinational path from it.
    assign alloc_ready_o = !full_o;
    assign alloc_idx_o   = tail_q;
    assign cam_head_o    = head_q;
    assign count_o       = count_q;
    assign cam_write_o      = wr_q;
    assign cam_write_addr_o = wr_addr_q;
    assign cam_write_data_o = wr_data_q;

    assign do_alloc  = alloc_valid_i && alloc_ready_o && !flush_i;
    assign do_retire = retire_i && !empty_o && !flush_i;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        valid_d   = valid_q;
        wr_d      = do_alloc;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end else begin
            // head == tail only when full or empty, so both updates never hit one slot.
            if (do_alloc) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + 1'b1;
                wr_addr_d       = tail_q;
                wr_data_d       = alloc_data_i;
            end
            if (do_retire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + 1'b1;
            end
            unique case ({do_alloc, do_retire})
                2'b10:   count_d = count_q + OneCount;
                2'b01:   count_d = count_q - OneCount;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Age is the distance from head; modulo wrap comes free from ADDRESS-bit arithmetic.
    always_comb begin
        logic [ADDRESS-1:0] q_age;
        logic [ADDRESS-1:0] j_age;
        q_age        = '0;
        j_age        = '0;
        cam_enable_o = '0;
        for (int r = 0; r < READ; r++) begin
            q_age = query_idx_i[r] - head_q;
            for (int j = 0; j < DEPTH; j++) begin
                j_age = ADDRESS'(j) - head_q;
                cam_enable_o[r][j] = valid_q[j] && (!query_valid_i[r] || (j_age < q_age));
            end
        end
    end

endmodule

// File: tb/tb_vlsu_cam_alloc.sv
// Bench for vlsu_cam_alloc: directed scenarios plus randomized traffic, all outputs compared
// every cycle against a queue-based reference model.
module tb_vlsu_cam_alloc;

    localparam int W = 50;
    localparam int D = 32;
    localparam int R = 3;
    localparam int A = 5;

    logic               clk = 1'b0;
    logic               arst_n = 1'b0;
    logic               flush_i = 1'b0;
    logic               alloc_valid_i = 1'b0;
    logic [W-1:0]       alloc_data_i = '0;
    logic               alloc_ready_o;
    logic [A-1:0]       alloc_idx_o;
    logic               retire_i = 1'b0;
    logic [R-1:0]       query_valid_i = '0;
    logic [R-1:0][A-1:0] query_idx_i = '0;
    logic               cam_write_o;
    logic [A-1:0]       cam_write_addr_o;
    logic [W-1:0]       cam_write_data_o;
    logic [A-1:0]       cam_head_o;
    logic [R-1:0][D-1:0] cam_enable_o;
    logic [A:0]         count_o;
    logic               full_o;
    logic               empty_o;

    vlsu_cam_alloc #(.WIDTH(W), .DEPTH(D), .READ(R)) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .flush_i          (flush_i),
        .alloc_valid_i    (alloc_valid_i),
        .alloc_data_i     (alloc_data_i),
        .alloc_ready_o    (alloc_ready_o),
        .alloc_idx_o      (alloc_idx_o),
        .retire_i         (retire_i),
        .query_valid_i    (query_valid_i),
        .query_idx_i      (query_idx_i),
        .cam_write_o      (cam_write_o),
        .cam_write_addr_o (cam_write_addr_o),
        .cam_write_data_o (cam_write_data_o),
        .cam_head_o       (cam_head_o),
        .cam_enable_o     (cam_enable_o),
        .count_o          (count_o),
        .full_o           (full_o),
        .empty_o          (empty_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: entries in allocation order, plus the head index.
    int           m_q[$];
    int           m_head;
    bit           m_wr;
    int           m_waddr;
    logic [W-1:0] m_wdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int age(input int x);
        return (x - m_head + D) % D;
    endfunction

    function automatic logic [D-1:0] exp_mask(input int r);
        logic [D-1:0] m;
        int k;
        m = '0;
        k = int'(query_idx_i[r]);
        foreach (m_q[i]) begin
            if (!query_valid_i[r] || age(m_q[i]) < age(k)) m[m_q[i]] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_head  = 0;
        m_wr    = 1'b0;
        m_waddr = 0;
        m_wdata = '0;
    endtask

    task automatic model_step();
        bit do_a, do_r;
        do_a = alloc_valid_i && (m_q.size() < D) && !flush_i;
        do_r = retire_i && (m_q.size() > 0) && !flush_i;
        m_wr = do_a;
        if (flush_i) begin
            m_q.delete();
            m_head = 0;
        end else begin
            if (do_a) begin
                m_waddr = (m_head + m_q.size()) % D;
                m_wdata = alloc_data_i;
                m_q.push_back(m_waddr);
            end
            if (do_r) begin
                void'(m_q.pop_front());
                m_head = (m_head + 1) % D;
            end
        end
    endtask

    task automatic check_all();
        check_eq("ready", alloc_ready_o, m_q.size() < D);
        check_eq("alloc_idx", alloc_idx_o, (m_head + m_q.size()) % D);
        check_eq("cam_write", cam_write_o, m_wr);
        if (m_wr) begin
            check_eq("write_addr", cam_write_addr_o, m_waddr);
            check_eq("write_data", cam_write_data_o, m_wdata);
        end
        check_eq("head", cam_head_o, m_head);
        check_eq("count", count_o, m_q.size());
        check_eq("full", full_o, m_q.size() == D);
        check_eq("empty", empty_o, m_q.size() == 0);
        for (int r = 0; r < R; r++)
            check_eq($sformatf("enable%0d", r), cam_enable_o[r], exp_mask(r));
    endtask

    // Inputs are set before calling; checks land mid-cycle, well clear of the edge.
    task automatic tick();
        #3;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit av, input logic [W-1:0] d, input bit ret, input bit fl);
        alloc_valid_i = av;
        alloc_data_i  = d;
        retire_i      = ret;
        flush_i       = fl;
    endtask

    task automatic apply_reset();
        arst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check_eq("rst_write", cam_write_o, 1'b0);
        check_eq("rst_addr", cam_write_addr_o, 0);
        check_eq("rst_data", cam_write_data_o, 0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        apply_reset();

        // Fill, then one refused alloc while full.
        for (int i = 0; i < 33; i++) begin
            set_in(1'b1, W'(i + 1), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        check_eq("fill_count", count_o, 32);
        check_eq("fill_full", full_o, 1'b1);
        check_eq("fill_held_write", cam_write_o, 1'b0);

        // Wrap: retire 4, alloc 4.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, W'(100 + i), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        check_eq("wrap_head", cam_head_o, 4);
        check_eq("wrap_tail", alloc_idx_o, 4);
        check_eq("wrap_count", count_o, 32);

        // Age mask on port 1.
        query_valid_i = 3'b010;
        query_idx_i[1] = A'(2);
        #1 check_eq("mask_idx2", cam_enable_o[1], 32'hFFFF_FFF3);
        query_idx_i[1] = A'(4);
        #1 check_eq("mask_head", cam_enable_o[1], 32'h0);
        query_valid_i = 3'b000;
        #1 check_eq("mask_all", cam_enable_o[1], 32'hFFFF_FFFF);
        tick();

        // Full: alloc + retire only retires.
        set_in(1'b1, W'(7), 1'b1, 1'b0);
        tick();
        check_eq("full_both_count", count_o, 31);

        // Build 10 entries, then alloc + retire together.
        set_in(1'b0, '0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, W'(200 + i), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, W'(300), 1'b1, 1'b0);
        tick();
        check_eq("both_count", count_o, 10);
        check_eq("both_head", cam_head_o, 1);
        check_eq("both_tail", alloc_idx_o, 11);

        // Flush overrides a concurrent alloc.
        set_in(1'b1, W'(400), 1'b0, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0);
        check_eq("flush_count", count_o, 0);
        check_eq("flush_write", cam_write_o, 1'b0);
        check_eq("flush_empty", empty_o, 1'b1);
        tick();

        // Reset in the cycle after a handshake drops the pending write.
        set_in(1'b1, W'(500), 1'b0, 1'b0);
        tick();
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0);
        #2 check_eq("pre_reset_write", cam_write_o, 1'b1);
        apply_reset();
        set_in(1'b1, W'(600), 1'b0, 1'b0);
        check_eq("resume_idx", alloc_idx_o, 0);
        tick();
        check_eq("resume_addr", cam_write_addr_o, 0);

        // Randomized traffic with alternating alloc-heavy and retire-heavy segments.
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 200; c++) begin
                int pa;
                pa = (seg % 2 == 0) ? 85 : 30;
                set_in($urandom_range(99) < pa, {$urandom(), $urandom()},
                       $urandom_range(99) < (100 - pa), $urandom_range(63) == 0);
                query_valid_i = R'($urandom());
                for (int r = 0; r < R; r++) query_idx_i[r] = A'($urandom());
                tick();
            end
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
